// File: rtl/seed_extend_engine.sv
// rtl/seed_extend_engine.sv - ungapped X-drop seed extension engine over a three-word DB window
//
// Purpose: takes a seed (query symbol index, absolute DB symbol index), fetches the
// DB words before, containing and after the seed, then extends left and right
// in parallel with match/mismatch scoring and X-drop termination, and reports
// the extended hit.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   query_valid_i/query_data_i  load the query word (used from the next seed on)
//   db_words_i                  DB length in words; words outside it are never fetched
//   seed_valid_i/seed_ready_o   seed handshake, seed_qpos_i / seed_dpos_i
//   mem_req_valid_o/ready_i     word fetch request, mem_req_addr_o = DB word index
//   mem_rsp_valid_i/data_i      fetch response
//   res_valid_o/res_ready_i     result handshake with res_start_o, res_end_o, res_score_o, res_pass_o
//   busy_o                      high whenever the engine is not idle
module seed_extend_engine #(
    parameter int WORD_W   = 512,
    parameter int SYM_W    = 2,
    parameter int SEED_LEN = 11,
    parameter int MAX_EXT  = 100,
    parameter int MATCH    = 1,
    parameter int MISMATCH = 3,
    parameter int XDROP    = 10,
    parameter int SCORE_W  = 12,
    parameter int SCORE_TH = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               query_valid_i,
    input  logic [WORD_W-1:0]  query_data_i,
    input  logic [31:0]        db_words_i,
    input  logic               seed_valid_i,
    output logic               seed_ready_o,
    input  logic [15:0]        seed_qpos_i,
    input  logic [31:0]        seed_dpos_i,
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic [31:0]        mem_req_addr_o,
    input  logic               mem_rsp_valid_i,
    input  logic [WORD_W-1:0]  mem_rsp_data_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [31:0]        res_start_o,
    output logic [31:0]        res_end_o,
    output logic [SCORE_W-1:0] res_score_o,
    output logic               res_pass_o,
    output logic               busy_o
);

    localparam int SYMS     = WORD_W / SYM_W;
    localparam int WIN_SYMS = 3 * SYMS;
    localparam int SMAX     = (1 << (SCORE_W - 1)) - 1;
    localparam int SMIN     = -(1 << (SCORE_W - 1));

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_EXTEND = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t state_q, state_d;

    // query_q follows query_valid_i at any time; qwork_q is the snapshot a seed
    // works against, so a mid-operation load only affects later seeds.
    logic [WORD_W-1:0] query_q;
    logic [WORD_W-1:0] qwork_q;

    // Window slot 0/1/2 holds DB word w-1/w/w+1.
    logic [WORD_W-1:0]   win_q [3];
    logic [3*WORD_W-1:0] window;
    logic [2:0]          rng_q;
    logic [2:0]          win_valid_q;
    logic [1:0]          fetch_idx_q;
    logic [1:0]          fetch_nxt;

    logic [15:0] qpos_q;
    logic [31:0] dpos_q;
    logic [31:0] w_q;
    logic [15:0] off_q;

    // Side 0 extends left, side 1 extends right.
    logic signed [SCORE_W-1:0] run_q [2];
    logic signed [SCORE_W-1:0] run_d [2];
    logic signed [SCORE_W-1:0] best_q [2];
    logic signed [SCORE_W-1:0] best_d [2];
    logic [15:0]               len_q [2];
    logic [15:0]               len_d [2];
    logic [15:0]               k_q [2];
    logic [15:0]               k_d [2];
    logic [1:0]                stop_q;
    logic [1:0]                stop_d;

    logic [31:0]        res_start_q;
    logic [31:0]        res_end_q;
    logic [SCORE_W-1:0] res_score_q;
    logic               res_pass_q;

    function automatic logic signed [SCORE_W-1:0] sat(input int v);
        if (v > SMAX) return SCORE_W'(SMAX);
        if (v < SMIN) return SCORE_W'(SMIN);
        return SCORE_W'(v);
    endfunction

    // First window slot at or after 'from' whose DB word exists; 3 means none left.
    function automatic logic [1:0] first_from(input logic [2:0] rng, input int from);
        for (int j = 0; j < 3; j++) begin
            if (j >= from && rng[j]) return 2'(j);
        end
        return 2'd3;
    endfunction

    assign window    = {win_q[2], win_q[1], win_q[0]};
    assign fetch_nxt = first_from(rng_q, int'(fetch_idx_q) + 1);

    // Seed decode: home word and which neighbours lie inside the DB.
    logic [31:0] seed_w;
    logic [2:0]  seed_rng;
    always_comb begin
        seed_w      = seed_dpos_i / 32'(SYMS);
        seed_rng[0] = (seed_w != 32'd0) && ((seed_w - 32'd1) < db_words_i);
        seed_rng[1] = seed_w < db_words_i;
        seed_rng[2] = ({1'b0, seed_w} + 33'd1) < {1'b0, db_words_i};
    end

    // One extension step per side; the stop checks come before the compare so
    // a side that cannot even take step 0 keeps best 0.
    int               qi   [2];
    int               wp   [2];
    int               nrun [2];
    logic [SYM_W-1:0] qsym [2];
    logic [SYM_W-1:0] dsym [2];
    logic             dval [2];
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            run_d[s]  = run_q[s];
            best_d[s] = best_q[s];
            len_d[s]  = len_q[s];
            k_d[s]    = k_q[s];
            stop_d[s] = stop_q[s];
            qsym[s]   = '0;
            dsym[s]   = '0;
            nrun[s]   = 0;
            if (s == 0) begin
                qi[s] = int'(qpos_q) - 1 - int'(k_q[s]);
                wp[s] = int'(off_q) + SYMS - 1 - int'(k_q[s]);
            end else begin
                qi[s] = int'(qpos_q) + SEED_LEN + int'(k_q[s]);
                wp[s] = int'(off_q) + SYMS + SEED_LEN + int'(k_q[s]);
            end
            if (wp[s] < 0 || wp[s] >= WIN_SYMS) dval[s] = 1'b0;
            else if (wp[s] < SYMS)              dval[s] = win_valid_q[0];
            else if (wp[s] < 2 * SYMS)          dval[s] = win_valid_q[1];
            else                                dval[s] = win_valid_q[2];

            if (state_q == S_EXTEND && !stop_q[s]) begin
                if (int'(k_q[s]) >= MAX_EXT || qi[s] < 0 || qi[s] > SYMS - 1 || !dval[s]) begin
                    stop_d[s] = 1'b1;
                end else begin
                    qsym[s] = SYM_W'(qwork_q >> (qi[s] * SYM_W));
                    dsym[s] = SYM_W'(window >> (wp[s] * SYM_W));
                    nrun[s] = (qsym[s] == dsym[s]) ? int'(run_q[s]) + MATCH
                                                   : int'(run_q[s]) - MISMATCH;
                    run_d[s] = sat(nrun[s]);
                    if (run_d[s] > best_q[s]) begin
                        best_d[s] = run_d[s];
                        len_d[s]  = k_q[s] + 16'd1;
                    end
                    k_d[s] = k_q[s] + 16'd1;
                    if (int'(run_d[s]) <= int'(best_d[s]) - XDROP) stop_d[s] = 1'b1;
                end
            end
        end
    end

    // Result assembled from the final-step values so it is ready on REPORT entry.
    logic [31:0]               r_start;
    logic [31:0]               r_end;
    logic signed [SCORE_W-1:0] r_score;
    always_comb begin
        r_start = dpos_q - 32'(len_d[0]);
        r_end   = dpos_q + 32'(SEED_LEN - 1) + 32'(len_d[1]);
        r_score = sat(SEED_LEN * MATCH + int'(best_d[0]) + int'(best_d[1]));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (seed_valid_i) state_d = S_REQ;
            S_REQ: begin
                if (fetch_idx_q == 2'd3)  state_d = S_EXTEND;
                else if (mem_req_ready_i) state_d = S_WAIT;
            end
            S_WAIT:   if (mem_rsp_valid_i) state_d = (fetch_nxt == 2'd3) ? S_EXTEND : S_REQ;
            S_EXTEND: if (stop_d == 2'b11) state_d = S_REPORT;
            S_REPORT: if (res_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        seed_ready_o    = (state_q == S_IDLE);
        busy_o          = (state_q != S_IDLE);
        mem_req_valid_o = (state_q == S_REQ) && (fetch_idx_q != 2'd3);
        mem_req_addr_o  = w_q + 32'(fetch_idx_q) - 32'd1;
        res_valid_o     = (state_q == S_REPORT);
    end

    assign res_start_o = res_start_q;
    assign res_end_o   = res_end_q;
    assign res_score_o = res_score_q;
    assign res_pass_o  = res_pass_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            query_q     <= '0;
            qwork_q     <= '0;
            rng_q       <= '0;
            win_valid_q <= '0;
            fetch_idx_q <= 2'd3;
            qpos_q      <= '0;
            dpos_q      <= '0;
            w_q         <= '0;
            off_q       <= '0;
            run_q       <= '{default: '0};
            best_q      <= '{default: '0};
            len_q       <= '{default: '0};
            k_q         <= '{default: '0};
            stop_q      <= '0;
            res_start_q <= '0;
            res_end_q   <= '0;
            res_score_q <= '0;
            res_pass_q  <= 1'b0;
        end else begin
            if (query_valid_i) query_q <= query_data_i;
            case (state_q)
                S_IDLE: begin
                    if (seed_valid_i) begin
                        qwork_q     <= query_valid_i ? query_data_i : query_q;
                        qpos_q      <= seed_qpos_i;
                        dpos_q      <= seed_dpos_i;
                        w_q         <= seed_w;
                        off_q       <= 16'(seed_dpos_i % 32'(SYMS));
                        rng_q       <= seed_rng;
                        win_valid_q <= '0;
                        fetch_idx_q <= first_from(seed_rng, 0);
                        run_q       <= '{default: '0};
                        best_q      <= '{default: '0};
                        len_q       <= '{default: '0};
                        k_q         <= '{default: '0};
                        stop_q      <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        win_q[fetch_idx_q]       <= mem_rsp_data_i;
                        win_valid_q[fetch_idx_q] <= 1'b1;
                        fetch_idx_q              <= fetch_nxt;
                    end
                end
                S_EXTEND: begin
                    run_q  <= run_d;
                    best_q <= best_d;
                    len_q  <= len_d;
                    k_q    <= k_d;
                    stop_q <= stop_d;
                    if (stop_d == 2'b11) begin
                        res_start_q <= r_start;
                        res_end_q   <= r_end;
                        res_score_q <= r_score;
                        res_pass_q  <= (int'(r_score) >= SCORE_TH);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seed_extend_engine.sv
// tb/tb_seed_extend_engine.sv - directed scoreboard bench for seed_extend_engine
module tb_seed_extend_engine;

    localparam int WORD_W = 512;

    typedef struct packed {
        logic [31:0] st;
        logic [31:0] en;
        logic [11:0] sc;
        logic        ps;
    } res_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              query_valid = 1'b0;
    logic [WORD_W-1:0] query_data = '0;
    logic [31:0]       db_words = 32'd10;
    logic              seed_valid = 1'b0;
    logic              seed_ready;
    logic [15:0]       seed_qpos = '0;
    logic [31:0]       seed_dpos = '0;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [31:0]       mem_req_addr;
    logic              mem_rsp_valid;
    logic [WORD_W-1:0] mem_rsp_data;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [31:0]       res_start;
    logic [31:0]       res_end;
    logic [11:0]       res_score;
    logic              res_pass;
    logic              busy;

    always #5 clk = ~clk;

    seed_extend_engine dut (
        .clk             (clk),
        .rst             (rst),
        .query_valid_i   (query_valid),
        .query_data_i    (query_data),
        .db_words_i      (db_words),
        .seed_valid_i    (seed_valid),
        .seed_ready_o    (seed_ready),
        .seed_qpos_i     (seed_qpos),
        .seed_dpos_i     (seed_dpos),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data),
        .res_valid_o     (res_valid),
        .res_ready_i     (res_ready),
        .res_start_o     (res_start),
        .res_end_o       (res_end),
        .res_score_o     (res_score),
        .res_pass_o      (res_pass),
        .busy_o          (busy)
    );

    logic [WORD_W-1:0] db_mem [0:15];
    int                req_log [$];
    res_t              exp_q [$];
    int                vectors = 0;
    int                errors = 0;
    logic              hold_ready = 1'b0;
    logic              pending = 1'b0;
    logic [31:0]       pend_addr = '0;
    logic [WORD_W-1:0] qry;

    // Memory: accepts when not held off, answers on the following cycle.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (pending) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = db_mem[pend_addr[3:0]];
                pending       = 1'b0;
            end
            mem_req_ready = !hold_ready;
            if (mem_req_valid && mem_req_ready && !rst) begin
                req_log.push_back(int'(mem_req_addr));
                pending   = 1'b1;
                pend_addr = mem_req_addr;
            end
        end
    end

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] w = '0;
        for (int i = 0; i < WORD_W / 32; i++) w = {w[WORD_W-33:0], 32'($urandom)};
        return w;
    endfunction

    function automatic logic [1:0] get_sym(input logic [WORD_W-1:0] w, input int i);
        return 2'(w >> (2 * i));
    endfunction

    function automatic logic [WORD_W-1:0] set_sym(input logic [WORD_W-1:0] w, input int i,
                                                  input logic [1:0] s);
        logic [WORD_W-1:0] m = WORD_W'(3) << (2 * i);
        return (w & ~m) | (WORD_W'(s) << (2 * i));
    endfunction

    task automatic fill_db();
        for (int i = 0; i < 16; i++) db_mem[i] = rand_word();
    endtask

    task automatic load_query(input logic [WORD_W-1:0] v);
        @(negedge clk);
        query_valid = 1'b1;
        query_data  = v;
        @(negedge clk);
        query_valid = 1'b0;
    endtask

    task automatic send_seed(input logic [15:0] q, input logic [31:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (seed_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            seed_qpos  = q;
            seed_dpos  = d;
            seed_valid = 1'b1;
            @(negedge clk);
            seed_valid = 1'b0;
        end
    endtask

    task automatic get_result(output res_t r, output bit ok);
        ok = 1'b0;
        r  = '0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                r  = '{res_start, res_end, res_score, res_pass};
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({seed_ready, busy, mem_req_valid, res_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/req/res=%b required 1000",
                     {seed_ready, busy, mem_req_valid, res_valid});
        end
        vectors++;
        if ({res_start, res_end, res_score, res_pass} !== 77'd0) begin
            errors++;
            $display("FAIL reset_res: start=%0d end=%0d score=%0d pass=%0d required all 0",
                     res_start, res_end, res_score, res_pass);
        end
    endtask

    task automatic test_full_match();
        res_t r, e;
        bit ok1, ok2;
        fill_db();
        qry = rand_word();
        db_mem[5] = qry;
        load_query(qry);
        req_log.delete();
        exp_q.push_back('{32'd1280, 32'd1490, 12'd211, 1'b1});
        send_seed(16'd100, 32'd1380, ok1);
        get_result(r, ok2);
        e = exp_q.pop_front();
        vectors++;
        if (!ok1 || !ok2 || r !== e) begin
            errors++;
            $display("FAIL full_match: got start=%0d end=%0d score=%0d pass=%0d ok=%0d%0d required %0d %0d %0d %0d",
                     r.st, r.en, r.sc, r.ps, ok1, ok2, e.st, e.en, e.sc, e.ps);
        end
        vectors++;
        if (req_log.size() != 3 || req_log[0] != 4 || req_log[1] != 5 || req_log[2] != 6) begin
            errors++;
            $display("FAIL full_match_addrs: got %p required '{4,5,6}", req_log);
        end
    endtask

    task automatic test_mismatch_both();
        res_t r, e;
        bit ok1, ok2;
        fill_db();
        qry = rand_word();
        db_mem[5] = ~qry;
        load_query(qry);
        exp_q.push_back('{32'd1380, 32'd1390, 12'd11, 1'b0});
        send_seed(16'd100, 32'd1380, ok1);
        get_result(r, ok2);
        e = exp_q.pop_front();
        vectors++;
        if (!ok1 || !ok2 || r !== e) begin
            errors++;
            $display("FAIL mismatch_both: got start=%0d end=%0d score=%0d pass=%0d ok=%0d%0d required %0d %0d %0d %0d",
                     r.st, r.en, r.sc, r.ps, ok1, ok2, e.st, e.en, e.sc, e.ps);
        end
    endtask

    task automatic test_low_edge();
        res_t r, e;
        bit ok1, ok2;
        fill_db();
        qry = rand_word();
        db_mem[0] = qry >> (2 * 47);
        load_query(qry);
        req_log.delete();
        exp_q.push_back('{32'd0, 32'd113, 12'd114, 1'b1});
        send_seed(16'd50, 32'd3, ok1);
        get_result(r, ok2);
        e = exp_q.pop_front();
        vectors++;
        if (!ok1 || !ok2 || r !== e) begin
            errors++;
            $display("FAIL low_edge: got start=%0d end=%0d score=%0d pass=%0d ok=%0d%0d required %0d %0d %0d %0d",
                     r.st, r.en, r.sc, r.ps, ok1, ok2, e.st, e.en, e.sc, e.ps);
        end
        vectors++;
        if (req_log.size() != 2 || req_log[0] != 0 || req_log[1] != 1) begin
            errors++;
            $display("FAIL low_edge_addrs: got %p required '{0,1}", req_log);
        end
    endtask

    task automatic test_xdrop_right();
        res_t r, e;
        bit ok1, ok2;
        logic [WORD_W-1:0] w;
        fill_db();
        qry = rand_word();
        w = ~qry;
        for (int i = 111; i < 115; i++) w = set_sym(w, i, get_sym(qry, i));
        db_mem[5] = w;
        load_query(qry);
        exp_q.push_back('{32'd1380, 32'd1394, 12'd15, 1'b0});
        send_seed(16'd100, 32'd1380, ok1);
        get_result(r, ok2);
        e = exp_q.pop_front();
        vectors++;
        if (!ok1 || !ok2 || r !== e) begin
            errors++;
            $display("FAIL xdrop_right: got start=%0d end=%0d score=%0d pass=%0d ok=%0d%0d required %0d %0d %0d %0d",
                     r.st, r.en, r.sc, r.ps, ok1, ok2, e.st, e.en, e.sc, e.ps);
        end
    endtask

    task automatic test_stall();
        res_t r, e;
        bit ok1, ok2;
        int bad;
        fill_db();
        qry = rand_word();
        db_mem[5] = qry;
        load_query(qry);
        req_log.delete();
        hold_ready = 1'b1;
        res_ready  = 1'b0;
        exp_q.push_back('{32'd1280, 32'd1490, 12'd211, 1'b1});
        send_seed(16'd100, 32'd1380, ok1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'd4) bad++;
        end
        vectors++;
        if (!ok1 || bad != 0 || req_log.size() != 0) begin
            errors++;
            $display("FAIL stall_req_hold: unstable cycles=%0d accepted=%0d ok=%0d required 0 0 1",
                     bad, req_log.size(), ok1);
        end
        @(posedge clk);
        #1 hold_ready = 1'b0;
        ok2 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok2 = 1'b1;
                break;
            end
        end
        r = '{res_start, res_end, res_score, res_pass};
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!res_valid || res_t'({res_start, res_end, res_score, res_pass}) !== r) bad++;
        end
        e = exp_q.pop_front();
        vectors++;
        if (!ok2 || bad != 0 || r !== e) begin
            errors++;
            $display("FAIL stall_result: got start=%0d end=%0d score=%0d pass=%0d unstable=%0d ok=%0d required %0d %0d %0d %0d",
                     r.st, r.en, r.sc, r.ps, bad, ok2, e.st, e.en, e.sc, e.ps);
        end
        res_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({seed_ready, res_valid} !== 2'b10) begin
            errors++;
            $display("FAIL stall_release: ready/res=%b required 10", {seed_ready, res_valid});
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) bad++;
        end
        vectors++;
        if (bad != 0 || req_log.size() != 3 || req_log[0] != 4 || req_log[1] != 5 || req_log[2] != 6) begin
            errors++;
            $display("FAIL stall_no_dup: extra result cycles=%0d requests=%p required 0 and '{4,5,6}",
                     bad, req_log);
        end
    endtask

    task automatic test_reset_mid_extend();
        res_t r, e;
        bit ok1, ok2;
        int bad;
        fill_db();
        qry = rand_word();
        db_mem[5] = qry;
        load_query(qry);
        send_seed(16'd100, 32'd1380, ok1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_valid) bad++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (!ok1 || {seed_ready, busy, res_valid} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_extend: ready/busy/res=%b ok=%0d required 100 1",
                     {seed_ready, busy, res_valid}, ok1);
        end
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (res_valid) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_no_result: result cycles=%0d required 0", bad);
        end
        load_query(qry);
        exp_q.push_back('{32'd1280, 32'd1490, 12'd211, 1'b1});
        send_seed(16'd100, 32'd1380, ok1);
        get_result(r, ok2);
        e = exp_q.pop_front();
        vectors++;
        if (!ok1 || !ok2 || r !== e) begin
            errors++;
            $display("FAIL rst_next_seed: got start=%0d end=%0d score=%0d pass=%0d ok=%0d%0d required %0d %0d %0d %0d",
                     r.st, r.en, r.sc, r.ps, ok1, ok2, e.st, e.en, e.sc, e.ps);
        end
    endtask

    // Second query is loaded while the first seed is running; the first seed
    // must still see the old query, the second seed the new one.
    task automatic test_back_to_back();
        res_t r, e;
        bit ok1, ok2;
        logic [WORD_W-1:0] qa;
        fill_db();
        qa = rand_word();
        db_mem[5] = qa;
        load_query(qa);
        exp_q.push_back('{32'd1280, 32'd1490, 12'd211, 1'b1});
        exp_q.push_back('{32'd1380, 32'd1390, 12'd11, 1'b0});
        send_seed(16'd100, 32'd1380, ok1);
        repeat (3) @(negedge clk);
        load_query(~qa);
        get_result(r, ok2);
        e = exp_q.pop_front();
        vectors++;
        if (!ok1 || !ok2 || r !== e) begin
            errors++;
            $display("FAIL b2b_first: got start=%0d end=%0d score=%0d pass=%0d ok=%0d%0d required %0d %0d %0d %0d",
                     r.st, r.en, r.sc, r.ps, ok1, ok2, e.st, e.en, e.sc, e.ps);
        end
        send_seed(16'd100, 32'd1380, ok1);
        get_result(r, ok2);
        e = exp_q.pop_front();
        vectors++;
        if (!ok1 || !ok2 || r !== e) begin
            errors++;
            $display("FAIL b2b_second: got start=%0d end=%0d score=%0d pass=%0d ok=%0d%0d required %0d %0d %0d %0d",
                     r.st, r.en, r.sc, r.ps, ok1, ok2, e.st, e.en, e.sc, e.ps);
        end
    endtask

    initial begin
        test_reset();
        test_full_match();
        test_mismatch_both();
        test_low_edge();
        test_xdrop_right();
        test_stall();
        test_reset_mid_extend();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seed_extend_engine.md
SEED_EXTEND_ENGINE -- requirements
Module: seed_extend_engine

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- WORD_W, 512, DB/query word width in bits
- SYM_W, 2, bits per nucleotide symbol
- SEED_LEN, 11, seed length in symbols
- MAX_EXT, 100, max extension per side in symbols; SEED_LEN+MAX_EXT SHALL be <= WORD_W/SYM_W
- MATCH, 1, score added per matching symbol
- MISMATCH, 3, score subtracted per mismatching symbol
- XDROP, 10, drop-off threshold
- SCORE_W, 12, signed score width
- SCORE_TH, 20, minimum total score for res_pass
REQ-002 The block SHALL have ports, one per line: name direction width meaning.
- clk in 1 clock; rst in 1 reset, synchronous, active-high
- query_valid in 1 load query word; query_data in WORD_W query (symbol i at bits [i*SYM_W +: SYM_W])
- db_words in 32 DB length in words
- seed_valid in 1, seed_ready out 1, seed_qpos in 16 query symbol index, seed_dpos in 32 absolute DB symbol index
- mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out 32 DB word index
- mem_rsp_valid in 1, mem_rsp_data in WORD_W
- res_valid out 1, res_ready in 1, res_start out 32, res_end out 32, res_score out SCORE_W, res_pass out 1
- busy out 1 high in every state except IDLE

Function
REQ-003 The block SHALL use states IDLE, REQ, WAIT, EXTEND, REPORT; seed_ready=1 only in IDLE.
REQ-004 query_valid SHALL load the query register in any state; a load outside IDLE SHALL take effect for the next seed only.
REQ-005 In IDLE, a seed_valid&seed_ready handshake SHALL capture qpos/dpos, set w=dpos/(WORD_W/SYM_W), and go to REQ next cycle.
REQ-006 REQ/WAIT SHALL fetch words w-1, w, w+1 in order into a 3-word window; each fetch: mem_req_valid held with mem_req_addr until mem_req_ready, then WAIT until mem_rsp_valid captures data.
REQ-007 Words with index <0 or >=db_words SHALL NOT be requested; they SHALL be marked invalid and fetching SHALL continue with the next word.
REQ-008 EXTEND SHALL process left and right sides in parallel, one symbol per side per cycle; step k (0-based) compares left query qpos-1-k vs DB dpos-1-k, right query qpos+SEED_LEN+k vs DB dpos+SEED_LEN+k.
REQ-009 Each side SHALL keep signed run score (start 0) and best score/best length (start 0/0); a match SHALL add MATCH, a mismatch SHALL subtract MISMATCH; best SHALL update when run > best (strictly).
REQ-010 A side SHALL stop when k reaches MAX_EXT, when its query index leaves [0, WORD_W/SYM_W-1], when its DB symbol lies in an invalid word, or when run <= best-XDROP after an update; a stopped side SHALL hold its values.
REQ-011 When both sides have stopped, the block SHALL enter REPORT next cycle; the side-stop check SHALL be evaluated before comparing, so a side stopped at k=0 contributes best 0.
REQ-012 REPORT SHALL drive res_valid=1 with res_start=dpos-bestLenL, res_end=dpos+SEED_LEN-1+bestLenR, res_score=SEED_LEN*MATCH+bestL+bestR, res_pass=(res_score>=SCORE_TH); the outputs SHALL stay stable until res_ready.
REQ-013 A handshake on res_valid&res_ready SHALL return the block to IDLE; seed_ready SHALL rise in the following cycle.
REQ-014 Score arithmetic SHALL be signed SCORE_W with saturation at the signed limits; addresses SHALL be unsigned 32-bit with no wrap (REQ-007 prevents underflow).
REQ-015 Seed-to-result latency with zero-wait memory SHALL be 1+3*2+max(stepsL,stepsR)+1 cycles, with one fewer fetch pair per skipped word.

Reset
REQ-016 rst SHALL force IDLE and clear seed_ready's blocking state, so seed_ready=1 on the first cycle after reset.
REQ-017 rst SHALL drive mem_req_valid=0, res_valid=0, busy=0, clear res_* and the scores, and clear window valid flags; the query register SHALL be cleared.
REQ-018 rst asserted mid-fetch or mid-extension SHALL abort the operation without emitting a result; a late mem_rsp_valid SHALL be ignored in IDLE.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Query==DB word 5, seed qpos=100, dpos=5*256+100, db_words=10 -> res_start=dpos-100, res_end=dpos+110, res_score=211, res_pass=1.
- Mismatches at left offset 0 and right offset 0 (both sides), qpos=100 -> res_score=11, res_start=dpos, res_end=dpos+10, res_pass=0.
- dpos=3 in word 0 with query match -> word -1 not requested (only addrs 0,1), left stops at 3 symbols, res_start=0.
- Right side with 4 matches then all mismatches -> X-drop after 4 mismatches (4-12<=4-10), bestLenR=4.
- mem_req_ready held low 20 cycles, res_ready held low 5 cycles -> request and result held stable, no duplicate fetch or result.
- rst pulsed during EXTEND -> res_valid stays 0, seed_ready=1 next cycle, next seed processed correctly.
